// File: rtl/gol_gen_sequencer.sv
// ============================================================================
// Module   : gol_gen_sequencer
// Brief    : Steps one Game of Life generation row by row over ping-pong BRAMs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gol_gen_sequencer #(
    parameter int Y_SIZE    = 720,
    parameter int Y_WIDTH   = 10,
    parameter int RD_LAT    = 1,
    parameter int GEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 run,
    output logic                 busy,
    output logic                 gen_done,
    output logic [GEN_WIDTH-1:0] gen_count,
    output logic                 src_bank,
    output logic                 rd_en,
    output logic [Y_WIDTH-1:0]   rd_addr,
    output logic                 rd_bank,
    output logic                 lb_shift,
    output logic                 lb_zero,
    output logic                 calc_valid,
    output logic [Y_WIDTH-1:0]   calc_row,
    input  logic                 ns_done,
    output logic                 wr_en,
    output logic [Y_WIDTH-1:0]   wr_addr,
    output logic                 wr_bank
);

    localparam int K_W  = Y_WIDTH + 1;
    localparam int WC_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [K_W-1:0]     Y_SIZE_K  = K_W'(Y_SIZE);
    localparam logic [Y_WIDTH-1:0] LAST_ROW  = Y_WIDTH'(Y_SIZE - 1);
    localparam logic [WC_W-1:0]    WAIT_INIT = (RD_LAT > 1) ? WC_W'(RD_LAT - 2) : '0;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_PRIME_ZERO = 4'd1,
        S_FETCH      = 4'd2,
        S_WAIT       = 4'd3,
        S_SHIFT      = 4'd4,
        S_CALC       = 4'd5,
        S_WAIT_NS    = 4'd6,
        S_WRITE      = 4'd7,
        S_DONE       = 4'd8
    } state_t;

    state_t                 state_q, state_d;
    logic [Y_WIDTH-1:0]     r_q, r_d;
    logic [K_W-1:0]         k_q, k_d;
    logic [1:0]             prime_q, prime_d;
    logic [WC_W-1:0]        wcnt_q, wcnt_d;
    logic                   skip_q, skip_d;
    logic                   src_bank_q, src_bank_d;
    logic [GEN_WIDTH-1:0]   gen_count_q, gen_count_d;
    logic                   done_prev_q;

    logic                   busy_q, gen_done_q, rd_en_q, lb_shift_q, lb_zero_q;
    logic                   calc_valid_q, wr_en_q;
    logic [Y_WIDTH-1:0]     rd_addr_q, calc_row_q;

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        k_d         = k_q;
        prime_d     = prime_q;
        wcnt_d      = wcnt_q;
        skip_d      = skip_q;
        src_bank_d  = src_bank_q;
        gen_count_d = gen_count_q;
        case (state_q)
            S_IDLE: begin
                if (start || (run && done_prev_q)) begin
                    r_d     = '0;
                    k_d     = '0;
                    prime_d = '0;
                    state_d = S_PRIME_ZERO;
                end
            end
            S_PRIME_ZERO: state_d = S_FETCH;
            S_FETCH: begin
                // Rows past the bottom edge are never read; the shift loads zeros.
                if (k_q < Y_SIZE_K) begin
                    skip_d = 1'b0;
                    if (RD_LAT > 1) begin
                        wcnt_d  = WAIT_INIT;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else begin
                    skip_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = S_SHIFT;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            S_SHIFT: begin
                k_d = k_q + 1'b1;
                if (prime_q < 2'd1) begin
                    prime_d = prime_q + 2'd1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC:    state_d = S_WAIT_NS;
            S_WAIT_NS: if (ns_done) state_d = S_WRITE;
            S_WRITE: begin
                if (r_q == LAST_ROW) begin
                    src_bank_d  = ~src_bank_q;
                    gen_count_d = gen_count_q + 1'b1;
                    state_d     = S_DONE;
                end else begin
                    r_d     = r_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so each is registered and
    // high for exactly the cycle its state occupies.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            r_q          <= '0;
            k_q          <= '0;
            prime_q      <= '0;
            wcnt_q       <= '0;
            skip_q       <= 1'b0;
            src_bank_q   <= 1'b0;
            gen_count_q  <= '0;
            done_prev_q  <= 1'b0;
            busy_q       <= 1'b0;
            gen_done_q   <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            lb_shift_q   <= 1'b0;
            lb_zero_q    <= 1'b0;
            calc_valid_q <= 1'b0;
            calc_row_q   <= '0;
            wr_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            k_q          <= k_d;
            prime_q      <= prime_d;
            wcnt_q       <= wcnt_d;
            skip_q       <= skip_d;
            src_bank_q   <= src_bank_d;
            gen_count_q  <= gen_count_d;
            done_prev_q  <= gen_done_q;
            busy_q       <= (state_d != S_IDLE);
            gen_done_q   <= (state_d == S_DONE);
            rd_en_q      <= (state_d == S_FETCH) && (k_d < Y_SIZE_K);
            if ((state_d == S_FETCH) && (k_d < Y_SIZE_K)) begin
                rd_addr_q <= k_d[Y_WIDTH-1:0];
            end
            lb_shift_q   <= (state_d == S_PRIME_ZERO) || (state_d == S_SHIFT);
            lb_zero_q    <= (state_d == S_PRIME_ZERO) || ((state_d == S_SHIFT) && skip_d);
            calc_valid_q <= (state_d == S_CALC);
            if (state_d == S_CALC) begin
                calc_row_q <= r_d;
            end
            wr_en_q      <= (state_d == S_WRITE);
        end
    end

    assign busy       = busy_q;
    assign gen_done   = gen_done_q;
    assign gen_count  = gen_count_q;
    assign src_bank   = src_bank_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign rd_bank    = src_bank_q;
    assign lb_shift   = lb_shift_q;
    assign lb_zero    = lb_zero_q;
    assign calc_valid = calc_valid_q;
    assign calc_row   = calc_row_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = calc_row_q;
    assign wr_bank    = ~src_bank_q;

endmodule

`default_nettype wire

// File: tb/tb_gol_gen_sequencer.sv
// ============================================================================
// Module   : tb_gol_gen_sequencer
// Brief    : Directed self-checking bench for gol_gen_sequencer (Y_SIZE=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gol_gen_sequencer;

    localparam int YS = 4;
    localparam int YW = 4;
    localparam int GW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_start = 1'b0, a_run = 1'b0, a_ns_done = 1'b0;
    logic          a_busy, a_gen_done, a_src_bank, a_rd_en, a_rd_bank, a_lb_shift, a_lb_zero;
    logic          a_calc_valid, a_wr_en, a_wr_bank;
    logic [GW-1:0] a_gen_count;
    logic [YW-1:0] a_rd_addr, a_calc_row, a_wr_addr;

    logic          b_start = 1'b0, b_run = 1'b0, b_ns_done = 1'b0;
    logic          b_busy, b_gen_done, b_src_bank, b_rd_en, b_rd_bank, b_lb_shift, b_lb_zero;
    logic          b_calc_valid, b_wr_en, b_wr_bank;
    logic [GW-1:0] b_gen_count;
    logic [YW-1:0] b_rd_addr, b_calc_row, b_wr_addr;

    gol_gen_sequencer #(.Y_SIZE(YS), .Y_WIDTH(YW), .RD_LAT(1), .GEN_WIDTH(GW)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .run(a_run), .busy(a_busy),
        .gen_done(a_gen_done), .gen_count(a_gen_count), .src_bank(a_src_bank),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_bank(a_rd_bank),
        .lb_shift(a_lb_shift), .lb_zero(a_lb_zero), .calc_valid(a_calc_valid),
        .calc_row(a_calc_row), .ns_done(a_ns_done), .wr_en(a_wr_en),
        .wr_addr(a_wr_addr), .wr_bank(a_wr_bank)
    );

    gol_gen_sequencer #(.Y_SIZE(YS), .Y_WIDTH(YW), .RD_LAT(3), .GEN_WIDTH(GW)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .run(b_run), .busy(b_busy),
        .gen_done(b_gen_done), .gen_count(b_gen_count), .src_bank(b_src_bank),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_bank(b_rd_bank),
        .lb_shift(b_lb_shift), .lb_zero(b_lb_zero), .calc_valid(b_calc_valid),
        .calc_row(b_calc_row), .ns_done(b_ns_done), .wr_en(b_wr_en),
        .wr_addr(b_wr_addr), .wr_bank(b_wr_bank)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Event codes: 100 zero shift, 300 data shift, 2xx read, 4xx calc, 5xx write, 600 done.
    int exp_base[19] = '{100, 200, 300, 201, 300, 400, 500, 202, 300, 401, 501,
                         203, 300, 402, 502, 100, 403, 503, 600};

    int   ev_a[$];
    int   ev_b[$];
    int   excl_bad = 0;
    logic last_wr_bank_a = 1'b0;
    int   ns_delay_a = 2;
    logic spur_a = 1'b0;

    int   b_rd_cyc[$];
    int   cyc_b = 0;
    int   b_lat_ok = 0, b_lat_bad = 0, b_zero_ok = 0, b_zero_bad = 0, b_last_wr = 0;
    logic b_wr_seen = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_rd_en)      ev_a.push_back(200 + int'(a_rd_addr));
        if (a_lb_shift)   ev_a.push_back(a_lb_zero ? 100 : 300);
        if (a_calc_valid) ev_a.push_back(400 + int'(a_calc_row));
        if (a_wr_en) begin
            ev_a.push_back(500 + int'(a_wr_addr));
            last_wr_bank_a = a_wr_bank;
        end
        if (a_gen_done)   ev_a.push_back(600);
        if ((a_rd_en && a_wr_en) || (int'(a_lb_shift) + int'(a_calc_valid) + int'(a_wr_en) > 1))
            excl_bad++;
    end

    always @(negedge clk) begin
        cyc_b++;
        if (b_rd_en) begin
            ev_b.push_back(200 + int'(b_rd_addr));
            b_rd_cyc.push_back(cyc_b);
        end
        if (b_lb_shift) begin
            if (b_lb_zero) begin
                ev_b.push_back(100);
                if (b_wr_seen) begin
                    if (cyc_b - b_last_wr == 2) b_zero_ok++;
                    else b_zero_bad++;
                end
            end else begin
                ev_b.push_back(300);
                if (b_rd_cyc.size() > 0 && cyc_b - b_rd_cyc[0] == 3) begin
                    b_lat_ok++;
                    void'(b_rd_cyc.pop_front());
                end else begin
                    b_lat_bad++;
                end
            end
        end
        if (b_calc_valid) ev_b.push_back(400 + int'(b_calc_row));
        if (b_wr_en) begin
            ev_b.push_back(500 + int'(b_wr_addr));
            b_last_wr = cyc_b;
            b_wr_seen = 1'b1;
        end
        if (b_gen_done) begin
            ev_b.push_back(600);
            b_wr_seen = 1'b0;
        end
    end

    // Next-state engine models: answer each calc pulse after a fixed delay.
    initial forever begin
        @(negedge clk);
        if (a_calc_valid) begin
            repeat (ns_delay_a) @(posedge clk);
            #1 a_ns_done = 1'b1;
            @(posedge clk);
            #1 a_ns_done = 1'b0;
        end else if (spur_a && a_rd_en && a_rd_addr == 4'd1) begin
            a_ns_done = 1'b1;
            @(posedge clk);
            #1 a_ns_done = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (b_calc_valid) begin
            repeat (2) @(posedge clk);
            #1 b_ns_done = 1'b1;
            @(posedge clk);
            #1 b_ns_done = 1'b0;
        end
    end

    task automatic pulse_start_a();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, input string tag);
        int i = 0;
        while (i < budget) begin
            @(negedge clk);
            if (a_gen_done) break;
            i++;
        end
        chk_eq(tag, a_gen_done, 1);
    endtask

    task automatic compare_trace(input string tag, input int q[$], input int base);
        chk_eq({tag, "_len"}, q.size() - base, 19);
        for (int i = 0; i < 19; i++) begin
            if (base + i < q.size()) chk_eq($sformatf("%s[%0d]", tag, i), q[base + i], exp_base[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int   base;
        int   stall_bad;
        int   i;
        logic [YW-1:0] cr;

        repeat (3) @(negedge clk);
        chk_eq("rst_busy", a_busy, 0);
        chk_eq("rst_strobes", {a_gen_done, a_rd_en, a_lb_shift, a_lb_zero, a_calc_valid, a_wr_en}, 0);
        chk_eq("rst_rd_addr", a_rd_addr, 0);
        chk_eq("rst_calc_row", a_calc_row, 0);
        chk_eq("rst_wr_addr", a_wr_addr, 0);
        chk_eq("rst_gen_count", a_gen_count, 0);
        chk_eq("rst_src_bank", a_src_bank, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Baseline generation
        base = ev_a.size();
        pulse_start_a();
        wait_done_a(200, "base_done");
        chk_eq("base_src_bank", a_src_bank, 1);
        chk_eq("base_gen_count", a_gen_count, 1);
        chk_eq("base_wr_bank", last_wr_bank_a, 1);
        repeat (3) @(negedge clk);
        compare_trace("base", ev_a, base);

        // Stall in WAIT_NS
        do_reset();
        ns_delay_a = 50;
        base = ev_a.size();
        pulse_start_a();
        i = 0;
        while (i < 50 && !a_calc_valid) begin
            @(negedge clk);
            i++;
        end
        chk_eq("stall_calc_seen", a_calc_valid, 1);
        cr = a_calc_row;
        stall_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (a_rd_en || a_wr_en || a_lb_shift || a_calc_row != cr) stall_bad++;
        end
        chk_eq("stall_quiet", stall_bad, 0);
        @(negedge clk);
        chk_eq("stall_resume_wr", a_wr_en, 1);
        chk_eq("stall_wr_addr", a_wr_addr, 0);
        wait_done_a(400, "stall_done");
        ns_delay_a = 2;
        repeat (3) @(negedge clk);
        compare_trace("stall", ev_a, base);

        // Free-running for three generations
        do_reset();
        a_run = 1'b1;
        pulse_start_a();
        for (int g = 1; g <= 3; g++) begin
            wait_done_a(200, $sformatf("run_done%0d", g));
            chk_eq($sformatf("run_src_bank%0d", g), a_src_bank, g % 2);
            chk_eq($sformatf("run_gen_count%0d", g), a_gen_count, g);
            if (g < 3) begin
                @(negedge clk);
                chk_eq("run_idle_gap", a_busy, 0);
                @(negedge clk);
                chk_eq("run_busy_back", a_busy, 1);
                chk_eq("run_rd_bank", a_rd_bank, last_wr_bank_a);
            end else begin
                a_run = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        chk_eq("run_stops", a_busy, 0);

        // Reset while computing row 2
        pulse_start_a();
        i = 0;
        while (i < 100 && !(a_calc_valid && a_calc_row == 4'd2)) begin
            @(negedge clk);
            i++;
        end
        chk_eq("mid_calc2_seen", a_calc_valid, 1);
        do_reset();
        chk_eq("mid_busy", a_busy, 0);
        chk_eq("mid_strobes", {a_gen_done, a_rd_en, a_lb_shift, a_lb_zero, a_calc_valid, a_wr_en}, 0);
        chk_eq("mid_src_bank", a_src_bank, 0);
        chk_eq("mid_gen_count", a_gen_count, 0);
        repeat (5) @(negedge clk);

        // Start while busy and spurious ns_done in FETCH
        spur_a = 1'b1;
        base = ev_a.size();
        pulse_start_a();
        repeat (3) @(negedge clk);
        pulse_start_a();
        wait_done_a(200, "inj_done");
        chk_eq("inj_gen_count", a_gen_count, 1);
        chk_eq("inj_src_bank", a_src_bank, 1);
        spur_a = 1'b0;
        repeat (3) @(negedge clk);
        compare_trace("inj", ev_a, base);

        // Read latency of 3
        base = ev_b.size();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        i = 0;
        while (i < 300 && !b_gen_done) begin
            @(negedge clk);
            i++;
        end
        chk_eq("lat3_done", b_gen_done, 1);
        chk_eq("lat3_src_bank", b_src_bank, 1);
        repeat (3) @(negedge clk);
        compare_trace("lat3", ev_b, base);
        chk_eq("lat3_shift_ok", b_lat_ok, 4);
        chk_eq("lat3_shift_bad", b_lat_bad, 0);
        chk_eq("lat3_rd_left", b_rd_cyc.size(), 0);
        chk_eq("lat3_zero_ok", b_zero_ok, 1);
        chk_eq("lat3_zero_bad", b_zero_bad, 0);

        chk_eq("excl", excl_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
